// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier.
// One result per WIDTH+1 cycles; product held between completions.
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              start_q;
    logic              start_edge;
    logic              load;
    logic              last;
    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_nxt;
    logic [CW-1:0]     cnt;

    // Next-state decode, operand-load strobe and the per-step sum
    always_comb begin
        state_d    = state;
        load       = 1'b0;
        start_edge = start & ~start_q;
        last       = (cnt == CW'(WIDTH - 1));
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_CALC;
                    load    = 1'b1;
                end
            end
            ST_CALC: begin
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start_edge) begin
                    state_d = ST_CALC;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, registered status flags and the shift-add datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_d;
            start_q <= start;
            busy    <= (state_d == ST_CALC);
            done    <= (state == ST_CALC) && last;
            if (load) begin
                mcand  <= PW'(a);
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == ST_CALC) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    product <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: vector table, scoreboard on done,
// plus hand-written sequences for the multi-cycle corner cases.
module tb_seq_shift_add_mult;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp;
    int n_err;
    logic [2*W-1:0] sb[$];
    vec_t tbl[6];

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Scoreboard: every done pulse must match the oldest pending result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: product %0h", product);
            end else begin
                check("product", int'(product), int'(sb.pop_front()));
            end
        end
    end

    task automatic launch(input logic [W-1:0] av,
                          input logic [W-1:0] bv,
                          input logic [2*W-1:0] pv);
        a     = av;
        b     = bv;
        start = 1'b1;
        sb.push_back(pv);
    endtask

    // Counts sampled cycles from the edge that sees start until done
    task automatic measure();
        int lat;
        int bc;
        bit got;
        lat = 0;
        bc  = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bc++;
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done in 40 cycles");
        end else begin
            check("latency", lat, W + 1);
            check("busy_cycles", bc, W);
        end
    endtask

    task automatic do_op(input logic [W-1:0] av,
                         input logic [W-1:0] bv,
                         input logic [2*W-1:0] pv);
        @(negedge clk);
        launch(av, bv, pv);
        measure();
    endtask

    initial begin
        int dc;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        tbl[0] = '{8'h0C, 8'h0D, 16'h009C};
        tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
        tbl[2] = '{8'h00, 8'h55, 16'h0000};
        tbl[3] = '{8'h10, 8'h10, 16'h0100};
        tbl[4] = '{8'h01, 8'hFF, 16'h00FF};
        tbl[5] = '{8'h80, 8'h02, 16'h0100};

        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_product", int'(product), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].p);
            repeat (2) @(negedge clk);
            check("hold", int'(product), int'(tbl[i].p));
        end

        // Level held high: exactly one operation
        @(negedge clk);
        launch(8'd3, 8'd5, 16'h000F);
        dc = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dc++;
        end
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("held_done_count", dc, 1);
        check("held_product", int'(product), 16'h000F);

        // Start pulse and operand change in CALC are ignored
        @(negedge clk);
        launch(8'd2, 8'd3, 16'h0006);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("ignore_done_count", dc, 1);
        check("ignore_product", int'(product), 16'h0006);
        check("ignore_busy", int'(busy), 0);

        // Reset in the middle of CALC aborts at once
        do_op(8'h10, 8'h10, 16'h0100);
        @(negedge clk);
        a     = 8'd7;
        b     = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_product", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("post_rst_done_count", dc, 0);
        check("post_rst_product", int'(product), 0);

        // Start in the DONE cycle: back-to-back with no idle gap
        do_op(8'h05, 8'h06, 16'h001E);
        launch(8'h0A, 8'h0B, 16'h006E);
        measure();
        repeat (3) @(negedge clk);
        check("b2b_product", int'(product), 16'h006E);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
